// File: rtl/adder_resp_checker_if.sv
// Stimulus, DUT-result and status bundle for adder_resp_checker.
// master drives stimulus and observes status; slave is the checker itself.
interface adder_resp_checker_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             err_flag;
    logic [CNT_W-1:0] first_err_idx;
    logic [WIDTH-1:0] first_err_exp;
    logic [WIDTH-1:0] first_err_got;

    modport master (
        output start, in_valid, a, b, c,
        input  busy, done, pass, chk_cnt, err_cnt, err_flag,
               first_err_idx, first_err_exp, first_err_got
    );

    modport slave (
        input  start, in_valid, a, b, c,
        output busy, done, pass, chk_cnt, err_cnt, err_flag,
               first_err_idx, first_err_exp, first_err_got
    );
endinterface

// File: rtl/adder_resp_checker.sv
// Response checker for a registered adder: predicts (a + b) mod 2^WIDTH, delays the
// prediction by LATENCY cycles, compares against c and records pass/error statistics.
module adder_resp_checker #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned NUM_SAMPLES = 100,
    parameter int unsigned CNT_W       = 16
) (
    input logic                  clk,
    input logic                  rst,
    adder_resp_checker_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [CNT_W-1:0] NumSamples = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] CntMax     = '1;

    state_e state_q, state_d;

    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_flag_q, err_flag_d;
    logic [CNT_W-1:0] err_idx_q, err_idx_d;
    logic [WIDTH-1:0] err_exp_q, err_exp_d;
    logic [WIDTH-1:0] err_got_q, err_got_d;

    // Delay line: stage LATENCY-1 lines up with the DUT output c.
    logic [LATENCY-1:0]            pipe_vld_q, pipe_vld_d;
    logic [LATENCY-1:0][WIDTH-1:0] pipe_exp_q, pipe_exp_d;
    logic [LATENCY-1:0][CNT_W-1:0] pipe_idx_q, pipe_idx_d;

    logic             push;
    logic             clear;
    logic [WIDTH-1:0] sum;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        chk_cnt_d   = chk_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_flag_d  = err_flag_q;
        err_idx_d   = err_idx_q;
        err_exp_d   = err_exp_q;
        err_got_d   = err_got_q;
        pipe_vld_d  = pipe_vld_q;
        pipe_exp_d  = pipe_exp_q;
        pipe_idx_d  = pipe_idx_q;
        push        = 1'b0;
        clear       = 1'b0;
        sum         = bus.a + bus.b;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    clear   = 1'b1;
                    state_d = StRun;
                end
            end
            StRun:   push = bus.in_valid;
            StDrain: push = 1'b0;
            default: state_d = StIdle;
        endcase

        if (clear) begin
            issue_cnt_d = '0;
            chk_cnt_d   = '0;
            err_cnt_d   = '0;
            err_flag_d  = 1'b0;
            err_idx_d   = '0;
            err_exp_d   = '0;
            err_got_d   = '0;
            pipe_vld_d  = '0;
            pipe_exp_d  = '0;
            pipe_idx_d  = '0;
        end else begin
            for (int i = int'(LATENCY) - 1; i > 0; i--) begin
                pipe_vld_d[i] = pipe_vld_q[i-1];
                pipe_exp_d[i] = pipe_exp_q[i-1];
                pipe_idx_d[i] = pipe_idx_q[i-1];
            end
            // Non-push cycles insert a bubble so the line keeps advancing.
            pipe_vld_d[0] = push;
            pipe_exp_d[0] = sum;
            pipe_idx_d[0] = issue_cnt_q;

            if (push && issue_cnt_q != CntMax) begin
                issue_cnt_d = issue_cnt_q + 1'b1;
            end

            if (pipe_vld_q[LATENCY-1]) begin
                if (chk_cnt_q != CntMax) begin
                    chk_cnt_d = chk_cnt_q + 1'b1;
                end
                if (pipe_exp_q[LATENCY-1] != bus.c) begin
                    if (err_cnt_q != CntMax) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (!err_flag_q) begin
                        err_flag_d = 1'b1;
                        err_idx_d  = pipe_idx_q[LATENCY-1];
                        err_exp_d  = pipe_exp_q[LATENCY-1];
                        err_got_d  = bus.c;
                    end
                end
            end

            if (state_q == StRun && issue_cnt_d == NumSamples) begin
                state_d = StDrain;
            end
            if (state_q == StDrain && chk_cnt_d == NumSamples) begin
                state_d = StDone;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            chk_cnt_q   <= '0;
            err_cnt_q   <= '0;
            err_flag_q  <= 1'b0;
            err_idx_q   <= '0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
            pipe_vld_q  <= '0;
            pipe_exp_q  <= '0;
            pipe_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_flag_q  <= err_flag_d;
            err_idx_q   <= err_idx_d;
            err_exp_q   <= err_exp_d;
            err_got_q   <= err_got_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_exp_q  <= pipe_exp_d;
            pipe_idx_q  <= pipe_idx_d;
        end
    end

    assign bus.busy          = (state_q == StRun) || (state_q == StDrain);
    assign bus.done          = (state_q == StDone);
    assign bus.pass          = (state_q == StDone) && !err_flag_q;
    assign bus.chk_cnt       = chk_cnt_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.err_flag      = err_flag_q;
    assign bus.first_err_idx = err_idx_q;
    assign bus.first_err_exp = err_exp_q;
    assign bus.first_err_got = err_got_q;

endmodule
